// File: rtl/fetch_queue_pkg.sv
// Shared types for the fetch-to-decode queue: the stored entry layout and
// the rule that marks a fetch address as misaligned.
package fetch_queue_pkg;

   localparam int PC_W    = 64;
   localparam int INSTR_W = 32;

   typedef struct packed {
      logic [PC_W-1:0]    pc;
      logic [INSTR_W-1:0] instr;
      logic               misalign;
   } fq_entry_t;

   function automatic logic is_misaligned(input logic [1:0] pc_lo);
      return pc_lo != 2'b00;
   endfunction

endpackage

// File: rtl/fetch_queue_wrap_ptr.sv
// Circular-buffer pointer. It advances on inc, wraps naturally modulo 2**W,
// and returns to zero on clr, which takes priority over inc.
module wrap_ptr #(
   parameter int W = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         inc,
   input  logic         clr,
   output logic [W-1:0] ptr
);

   // NOTE: sequential state is assigned with <= only, so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         ptr <= '0;
      else if (clr)
         ptr <= '0;
      else if (inc)
         ptr <= ptr + W'(1);
   end

endmodule

// File: rtl/fetch_queue.sv
// Decoupling FIFO between fetch and decode. It holds {pc, instr, misalign}
// entries, presents the oldest entry to decode, and empties on flush_Q.
module fetch_queue
   import fetch_queue_pkg::*;
#(
   parameter  int N     = 64,
   parameter  int DEPTH = 4,
   localparam int AW    = $clog2(DEPTH),
   localparam int CW    = AW + 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          push_valid_F,
   output logic          push_ready_F,
   input  logic [N-1:0]  pc_F,
   input  logic [31:0]   instr_F,
   output logic          pop_valid_D,
   input  logic          pop_ready_D,
   output logic [N-1:0]  pc_D,
   output logic [31:0]   instr_D,
   output logic          misalign_D,
   input  logic          flush_Q,
   output logic [CW-1:0] count_Q
);

   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   fq_entry_t     mem [DEPTH];
   fq_entry_t     entry_in;
   fq_entry_t     head;
   logic          push_fire;
   logic          pop_fire;

   // A full queue refuses a push even when a pop fires in the same cycle,
   // so readiness never depends on pop_ready_D.
   assign push_ready_F = (count_Q != CW'(DEPTH)) && !flush_Q;
   assign pop_valid_D  = (count_Q != '0) && !flush_Q;
   assign push_fire    = push_valid_F && push_ready_F;
   assign pop_fire     = pop_valid_D && pop_ready_D;

   // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
   always_comb begin
      entry_in          = '0;
      entry_in.pc       = PC_W'(pc_F);
      entry_in.instr    = instr_F;
      entry_in.misalign = is_misaligned(pc_F[1:0]);
   end

   // NOTE: the storage array has no reset; empty slots are never presented
   // because pop_valid_D depends only on count_Q.
   always_ff @(posedge clk) begin
      if (push_fire)
         mem[wr_ptr] <= entry_in;
   end

   wrap_ptr #(.W(AW)) u_rd_ptr (
      .clk   (clk),
      .rst_n (reset),
      .inc   (pop_fire),
      .clr   (flush_Q),
      .ptr   (rd_ptr)
   );

   wrap_ptr #(.W(AW)) u_wr_ptr (
      .clk   (clk),
      .rst_n (reset),
      .inc   (push_fire),
      .clr   (flush_Q),
      .ptr   (wr_ptr)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         count_Q <= '0;
      else if (flush_Q)
         count_Q <= '0;
      else if (push_fire && !pop_fire)
         count_Q <= count_Q + CW'(1);
      else if (pop_fire && !push_fire)
         count_Q <= count_Q - CW'(1);
   end

   assign head = mem[rd_ptr];

   // Decode sees zeros while the head is invalid, not stale storage.
   always_comb begin
      pc_D       = '0;
      instr_D    = '0;
      misalign_D = 1'b0;
      if (pop_valid_D) begin
         pc_D       = N'(head.pc);
         instr_D    = head.instr;
         misalign_D = head.misalign;
      end
   end

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue. The driver applies directed and random
// stimulus, and a negedge monitor checks the outputs against a queue model.
module tb_fetch_queue;

   localparam int N     = 64;
   localparam int DEPTH = 4;

   typedef struct {
      logic [63:0] pc;
      logic [31:0] instr;
      logic        mis;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        push_valid_F = 1'b0;
   logic        push_ready_F;
   logic [63:0] pc_F = '0;
   logic [31:0] instr_F = '0;
   logic        pop_valid_D;
   logic        pop_ready_D = 1'b0;
   logic [63:0] pc_D;
   logic [31:0] instr_D;
   logic        misalign_D;
   logic        flush_Q = 1'b0;
   logic [2:0]  count_Q;

   exp_t model_q[$];
   exp_t pend_entry;
   bit   pend_push  = 1'b0;
   bit   pend_flush = 1'b0;
   int   checks = 0;
   int   errors = 0;

   fetch_queue #(.N(N), .DEPTH(DEPTH)) dut (
      .clk          (clk),
      .reset        (reset),
      .push_valid_F (push_valid_F),
      .push_ready_F (push_ready_F),
      .pc_F         (pc_F),
      .instr_F      (instr_F),
      .pop_valid_D  (pop_valid_D),
      .pop_ready_D  (pop_ready_D),
      .pc_D         (pc_D),
      .instr_D      (instr_D),
      .misalign_D   (misalign_D),
      .flush_Q      (flush_Q),
      .count_Q      (count_Q)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: checks the outputs halfway through each cycle. When a pop
   // fires, it consumes the model head and records whether a push is accepted.
   always @(negedge clk) begin
      if (reset) begin
         automatic int size      = model_q.size();
         automatic bit exp_ready = (size != DEPTH) && !flush_Q;
         automatic bit exp_valid = (size != 0) && !flush_Q;
         check("count_Q", 64'(count_Q), 64'(size));
         check("push_ready_F", 64'(push_ready_F), 64'(exp_ready));
         check("pop_valid_D", 64'(pop_valid_D), 64'(exp_valid));
         if (exp_valid) begin
            check("pc_D", pc_D, model_q[0].pc);
            check("instr_D", 64'(instr_D), 64'(model_q[0].instr));
            check("misalign_D", 64'(misalign_D), 64'(model_q[0].mis));
            if (pop_ready_D)
               void'(model_q.pop_front());
         end else begin
            check("pc_D_idle", pc_D, 64'd0);
            check("instr_D_idle", 64'(instr_D), 64'd0);
            check("misalign_D_idle", 64'(misalign_D), 64'd0);
         end
         pend_flush       = flush_Q;
         pend_push        = push_valid_F && exp_ready;
         pend_entry.pc    = pc_F;
         pend_entry.instr = instr_F;
         pend_entry.mis   = (pc_F[1:0] != 2'b00);
      end
   end

   // Drives one cycle of inputs, then folds the accepted push or flush into the model.
   task automatic step(input bit pv, input logic [63:0] pc, input logic [31:0] ins,
                       input bit pr, input bit fl);
      push_valid_F = pv;
      pc_F         = pc;
      instr_F      = ins;
      pop_ready_D  = pr;
      flush_Q      = fl;
      @(posedge clk);
      #1;
      if (pend_flush)
         model_q.delete();
      else if (pend_push)
         model_q.push_back(pend_entry);
      pend_push  = 1'b0;
      pend_flush = 1'b0;
   endtask

   task automatic idle();
      step(1'b0, 64'd0, 32'd0, 1'b0, 1'b0);
   endtask

   initial begin
      #52;
      reset = 1'b1;
      #1;
      check("reset_count", 64'(count_Q), 64'd0);
      check("reset_pop_valid", 64'(pop_valid_D), 64'd0);
      check("reset_pc_D", pc_D, 64'd0);
      check("reset_push_ready", 64'(push_ready_F), 64'd1);
      @(posedge clk);
      #1;

      // Single entry: it becomes visible one cycle after the push.
      step(1'b1, 64'd4, 32'h8B020020, 1'b0, 1'b0);
      idle();
      step(1'b0, 64'd0, 32'd0, 1'b1, 1'b0);

      // Fill, pop two, refill across the wrap.
      for (int i = 0; i < 4; i++)
         step(1'b1, 64'(i * 4), 32'hA000_0000 + 32'(i), 1'b0, 1'b0);
      idle();
      step(1'b0, 64'd0, 32'd0, 1'b1, 1'b0);
      step(1'b0, 64'd0, 32'd0, 1'b1, 1'b0);
      step(1'b1, 64'd16, 32'hA000_0004, 1'b0, 1'b0);
      step(1'b1, 64'd20, 32'hA000_0005, 1'b0, 1'b0);

      // Full queue with a simultaneous pop: the push is refused, then accepted next cycle.
      step(1'b1, 64'd24, 32'hA000_0006, 1'b1, 1'b0);
      step(1'b1, 64'd24, 32'hA000_0006, 1'b0, 1'b0);
      idle();
      for (int i = 0; i < 5; i++)
         step(1'b0, 64'd0, 32'd0, 1'b1, 1'b0);

      // A flush with a push in the same cycle drops everything, including that push.
      for (int i = 0; i < 3; i++)
         step(1'b1, 64'(100 + i * 4), 32'hB000_0000 + 32'(i), 1'b0, 1'b0);
      step(1'b1, 64'd69857, 32'hDEAD_BEEF, 1'b0, 1'b1);
      step(1'b1, 64'd69857, 32'h1234_5678, 1'b0, 1'b0);
      idle();
      step(1'b0, 64'd0, 32'd0, 1'b1, 1'b0);

      // Asynchronous reset between clock edges with two entries queued.
      step(1'b1, 64'd200, 32'hC000_0000, 1'b0, 1'b0);
      step(1'b1, 64'd204, 32'hC000_0001, 1'b0, 1'b0);
      push_valid_F = 1'b0;
      #2;
      reset = 1'b0;
      #1;
      check("async_reset_count", 64'(count_Q), 64'd0);
      check("async_reset_pop_valid", 64'(pop_valid_D), 64'd0);
      check("async_reset_pc_D", pc_D, 64'd0);
      model_q.delete();
      pend_push  = 1'b0;
      pend_flush = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b1;
      idle();

      // Randomised traffic with occasional flushes.
      for (int i = 0; i < 2000; i++)
         step($urandom_range(0, 9) < 7, {$urandom, $urandom}, $urandom,
              $urandom_range(0, 9) < 6, $urandom_range(0, 99) < 3);
      idle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Decoupling buffer between the fetch stage and decode. Captures each fetched {PC, instruction} pair into a small circular FIFO, presents the oldest entry to decode with a valid/ready handshake, and tags misaligned fetch addresses for the exception logic. A single flush input (taken branch or exception redirect) discards all buffered entries so decode never sees wrong-path instructions.

## Interface
Parameters:
- N, 64, PC width in bits
- DEPTH, 4, number of entries; power of two, at least 2

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- push_valid_F  in  1  fetch presents a new entry this cycle
- push_ready_F  out  1  queue accepts an entry this cycle
- pc_F  in  N  PC of the fetched instruction (imem address)
- instr_F  in  32  fetched instruction word
- pop_valid_D  out  1  head entry is valid
- pop_ready_D  in  1  decode consumes the head this cycle
- pc_D  out  N  PC of head entry
- instr_D  out  32  instruction of head entry
- misalign_D  out  1  head entry's PC had bits [1:0] != 0
- flush_Q  in  1  discard all entries (branch taken or exception redirect)
- count_Q  out  $clog2(DEPTH)+1  number of valid entries

## Operation
- Storage: DEPTH entries of {pc, instr, misalign}; read pointer rd_ptr, write pointer wr_ptr, both $clog2(DEPTH) bits and wrapping modulo DEPTH; occupancy counter count_Q.
- Push fires when push_valid_F && push_ready_F: writes {pc_F, instr_F, pc_F[1:0] != 2'b00} at wr_ptr; wr_ptr increments.
- Pop fires when pop_valid_D && pop_ready_D: rd_ptr increments.
- push_ready_F = (count_Q != DEPTH) && !flush_Q. No bypass: a full queue refuses a push even when a pop fires in the same cycle.
- pop_valid_D = (count_Q != 0) && !flush_Q.
- Both fire in one cycle: count_Q unchanged, both pointers advance.
- Only push: count_Q + 1. Only pop: count_Q - 1. count_Q never exceeds DEPTH and never goes below 0.
- When pop_valid_D = 0: pc_D, instr_D, misalign_D are driven to 0 (instr_D = 0 is not interpreted by decode while invalid).
- flush_Q = 1: at the next rising edge rd_ptr = wr_ptr = 0 and count_Q = 0. Any push or pop requested in that cycle is ignored (ready/valid already forced low). Flush has priority over all other events.
- misalign is data only; the queue does not stall or drop misaligned entries.

## Timing
- Reset (reset = 0, asynchronous): rd_ptr = 0, wr_ptr = 0, count_Q = 0, so pop_valid_D = 0, pc_D = 0, instr_D = 0, misalign_D = 0, push_ready_F = 1. Storage contents need not be cleared. Reset asserted mid-operation drops all entries immediately, without waiting for a clock edge.
- Push-to-pop latency: one cycle. An entry pushed at edge k is visible on pc_D/instr_D after edge k, with pop_valid_D = 1 in cycle k+1.
- Head outputs are combinational reads of the entry at rd_ptr; they change only after a clock edge, a reset, or a flush_Q transition.
- Sustained throughput: one push and one pop per cycle whenever 0 < count_Q < DEPTH.
- Wrap-around: after DEPTH pushes, wr_ptr returns to 0. Order is preserved across the wrap.
- Flush is synchronous. count_Q reads 0 from the edge after flush_Q is sampled high.

## Structure
- Package fetch_queue_pkg holds:
  - typedef fq_entry_t, a packed struct {logic [N-1:0] pc; logic [31:0] instr; logic misalign;} parameterised through a package localparam PC_W = 64.
  - localparam INSTR_W = 32.
- Sub-module wrap_ptr: a $clog2(DEPTH)-bit pointer with inc, clr, async active-low reset, and natural modulo wrap. It is instantiated twice (rd_ptr and wr_ptr).
- Top-level fetch_queue holds the storage array, count_Q logic, handshake and flush gating.

## Test plan
- Reset: hold reset = 0 for 50 ns, then release -> count_Q = 0, pop_valid_D = 0, pc_D = 0, push_ready_F = 1.
- Single entry: push pc_F = 64'd4, instr_F = 32'h8B020020 with pop_ready_D = 0 -> next cycle pop_valid_D = 1, pc_D = 4, instr_D = 32'h8B020020, misalign_D = 0, count_Q = 1.
- Fill and wrap: push PCs 0, 4, 8, 12 with no pops -> count_Q = 4 and push_ready_F = 0. Pop twice, push 16 and 20, then pop all -> pc_D sequence is 0, 4, 8, 12, 16, 20.
- Full with simultaneous pop: queue full, push_valid_F = 1, pop_ready_D = 1 -> pop fires, push refused, count_Q = 3. In the next cycle the push is accepted and count_Q = 4.
- Flush: 3 entries queued, flush_Q = 1 for one cycle together with push_valid_F = 1 and pc_F = 64'd69857 -> count_Q = 0 after the edge and pop_valid_D = 0. A following push of 69857 then appears with misalign_D = 1.
- Async reset mid-stream: reset = 0 between clock edges while count_Q = 2 -> count_Q = 0 and pop_valid_D = 0 immediately, before the next edge.
